// File: rtl/mem_stage_pkg.sv
// Shared pipeline package: control-bit positions within the EX/MEM control
// buses, the default data memory size and a small branch-decision helper.
package mem_stage_pkg;

  // Default data memory word-address width (2^8 = 256 words of 32 bits)
  localparam int ADDR_BITS_DEFAULT = 8;

  // WB control bus bit positions
  localparam int REGWRITE = 1;
  localparam int MEMTOREG = 0;

  // MEM control bus bit positions
  localparam int BRANCH   = 2;
  localparam int MEMREAD  = 1;
  localparam int MEMWRITE = 0;

  // Branch is taken when the instruction is a branch and the ALU compare hit
  function automatic logic branch_taken(input logic [2:0] m_ctl, input logic zero_flag);
    return m_ctl[BRANCH] & zero_flag;
  endfunction

endpackage

// File: rtl/data_memory.sv
// Single-port data memory: synchronous write, registered read with
// read-before-write ordering. The array itself is never reset; only the read
// register is. Writes are suppressed while rst_n is low.
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic                 i_re,
  input  logic [ADDR_BITS-1:0] i_addr,
  input  logic [31:0]          i_wdata,
  output logic [31:0]          o_rdata
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] r_mem [0:DEPTH-1];
  logic [31:0] r_rdata;
  logic        w_we;

  // A write landing on an edge while reset is held is cancelled
  assign w_we = i_we & rst_n;

  // Storage update; deliberately without reset so contents survive rst_n
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  // Read register: old word on a same-edge write, zero when no read requested
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= 32'h0000_0000;
    end else if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end else begin
      r_rdata <= 32'h0000_0000;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: branch decision, data memory access and the MEM/WB
// pipeline register. Branch outputs are combinational; everything else is
// registered with one cycle of latency and no stall.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_BITS = ADDR_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  wb_ctlout,
  input  logic [2:0]  m_ctlout,
  input  logic [31:0] add_result,
  input  logic        zero,
  input  logic [31:0] alu_result,
  input  logic [31:0] rdata2out,
  input  logic [4:0]  five_bit_muxout,
  output logic        pcsrc,
  output logic [31:0] branch_target,
  output logic [1:0]  mem_wb_ctl,
  output logic [31:0] read_data,
  output logic [31:0] mem_alu_result,
  output logic [4:0]  mem_write_reg
);

  logic [ADDR_BITS-1:0] w_word_idx;
  logic                 w_mem_we;
  logic                 w_mem_re;
  logic [1:0]           r_wb_ctl;
  logic [31:0]          r_alu_result;
  logic [4:0]           r_write_reg;

  // Byte offset bits and bits above the array size are dropped, so
  // out-of-range addresses wrap onto the array
  assign w_word_idx = alu_result[ADDR_BITS+1:2];
  assign w_mem_we   = m_ctlout[MEMWRITE];
  assign w_mem_re   = m_ctlout[MEMREAD];

  // Branch resolution, live even during reset
  assign pcsrc         = branch_taken(m_ctlout, zero);
  assign branch_target = add_result;

  data_memory #(
    .ADDR_BITS (ADDR_BITS)
  ) u_data_memory (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_word_idx),
    .i_wdata (rdata2out),
    .o_rdata (read_data)
  );

  // MEM/WB pipeline register, loads every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_ctl     <= 2'b00;
      r_alu_result <= 32'h0000_0000;
      r_write_reg  <= 5'd0;
    end else begin
      r_wb_ctl     <= wb_ctlout;
      r_alu_result <= alu_result;
      r_write_reg  <= five_bit_muxout;
    end
  end

  assign mem_wb_ctl     = r_wb_ctl;
  assign mem_alu_result = r_alu_result;
  assign mem_write_reg  = r_write_reg;

endmodule
